// File: rtl/linear_interpolator_if.sv
// Sample/strobe bundle for linear_interpolator; master drives samples and ticks, slave is the interpolator.
// With INTERP_OVERRUN_FLAG_EN defined the bundle also carries the sticky overrun flag.
interface linear_interpolator_if #(
   parameter int BITS_ADC  = 8,
   parameter int BITS_ACUM = 12
);
   localparam int BIT_DIFF = BITS_ACUM - BITS_ADC;
   localparam int KW       = $clog2(BIT_DIFF) + 1;

   logic [KW-1:0]       k;
   logic [BITS_ADC-1:0] sample_in;
   logic                rdy_in;
   logic                in_ready;
   logic                out_tick;
   logic [BITS_ADC-1:0] sample_out;
   logic                rdy_out;
`ifdef INTERP_OVERRUN_FLAG_EN
   logic                overrun;

   modport master (output k, sample_in, rdy_in, out_tick,
                   input  in_ready, sample_out, rdy_out, overrun);
   modport slave  (input  k, sample_in, rdy_in, out_tick,
                   output in_ready, sample_out, rdy_out, overrun);
`else
   modport master (output k, sample_in, rdy_in, out_tick,
                   input  in_ready, sample_out, rdy_out);
   modport slave  (input  k, sample_in, rdy_in, out_tick,
                   output in_ready, sample_out, rdy_out);
`endif
endinterface

// File: rtl/linear_interpolator.sv
// Linear interpolating upsampler: each input interval is re-expanded into 2^k samples paced by out_tick.
// Optional INTERP_OVERRUN_FLAG_EN adds a sticky flag set whenever an input sample is dropped.
module linear_interpolator #(
   parameter int BITS_ADC  = 8,
   parameter int BITS_ACUM = 12
) (
   input logic                 clk,
   input logic                 rst,
   linear_interpolator_if.slave bus
);
   localparam int BIT_DIFF = BITS_ACUM - BITS_ADC;
   localparam int KW       = $clog2(BIT_DIFF) + 1;
   localparam int PW       = (BIT_DIFF > 0) ? BIT_DIFF : 1;

   typedef enum logic [1:0] {PRIME, WAIT, RUN} state_t;

   state_t                state, state_nxt;
   logic [BITS_ADC-1:0]   prev, cur, pending;
   logic                  pend_full;
   logic [KW-1:0]         k_lat, k_clamp;
   logic signed [BITS_ADC:0] delta;
   logic [BITS_ACUM-1:0]  acc;
   logic [PW-1:0]         phase, df_m1;
   logic                  consume, prime_load, seg_start, emit, seg_end;
   logic                  store, drop;

   always_comb begin
      k_clamp = (bus.k > KW'(BIT_DIFF)) ? KW'(BIT_DIFF) : bus.k;
      df_m1   = PW'((32'd1 << k_lat) - 32'd1);
   end

   // Next-state and one-cycle control strobes for prime, segment start and per-tick output
   always_comb begin
      state_nxt  = state;
      consume    = 1'b0;
      prime_load = 1'b0;
      seg_start  = 1'b0;
      emit       = 1'b0;
      seg_end    = 1'b0;
      case (state)
         PRIME: begin
            if (pend_full) begin
               prime_load = 1'b1;
               consume    = 1'b1;
               state_nxt  = WAIT;
            end
         end
         WAIT: begin
            if (pend_full) begin
               seg_start = 1'b1;
               consume   = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (bus.out_tick) begin
               emit = 1'b1;
               if (phase == df_m1) begin
                  seg_end   = 1'b1;
                  state_nxt = WAIT;
               end
            end
         end
         default: state_nxt = PRIME;
      endcase
   end

   // A slot being emptied this cycle can accept a new sample in the same cycle
   always_comb begin
      store = bus.rdy_in && (!pend_full || consume);
      drop  = bus.rdy_in && pend_full && !consume;
   end

   assign bus.in_ready = !pend_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= PRIME;
      else     state <= state_nxt;
   end

   // The accumulator holds prev scaled by 2^k, so a right shift by k yields each interpolated point
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev           <= '0;
         cur            <= '0;
         pending        <= '0;
         pend_full      <= 1'b0;
         k_lat          <= '0;
         delta          <= '0;
         acc            <= '0;
         phase          <= '0;
         bus.rdy_out    <= 1'b0;
         bus.sample_out <= '0;
      end else begin
         bus.rdy_out    <= emit;
         bus.sample_out <= emit ? BITS_ADC'(acc >> k_lat) : '0;

         if (store) begin
            pending   <= bus.sample_in;
            pend_full <= 1'b1;
         end else if (consume) begin
            pend_full <= 1'b0;
         end

         if (prime_load) prev <= pending;

         if (seg_start) begin
            cur   <= pending;
            k_lat <= k_clamp;
            delta <= $signed({1'b0, pending}) - $signed({1'b0, prev});
            acc   <= BITS_ACUM'(prev) << k_clamp;
            phase <= '0;
         end else if (emit) begin
            acc <= acc + BITS_ACUM'(delta);
            if (seg_end) prev  <= cur;
            else         phase <= phase + 1'b1;
         end
      end
   end

`ifdef INTERP_OVERRUN_FLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       bus.overrun <= 1'b0;
      else if (drop) bus.overrun <= 1'b1;
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_linear_interpolator.sv
// Directed bench for linear_interpolator: table-driven ramps plus hand sequences for overrun, k change and reset.
// Overrun flag checks are compiled in only when INTERP_OVERRUN_FLAG_EN is defined.
module tb_linear_interpolator;
   logic clk = 1'b0;
   logic rst = 1'b1;

   linear_interpolator_if #(.BITS_ADC(8), .BITS_ACUM(12)) bus ();

   linear_interpolator #(.BITS_ADC(8), .BITS_ACUM(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       do_rst;
      logic [2:0] k;
      logic       rin;
      logic [7:0] s;
      logic       tick;
      logic       er;
      logic [7:0] eo;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   function automatic void add_vec(input logic r, input logic [2:0] k, input logic rin,
                                   input logic [7:0] s, input logic tick,
                                   input logic er, input logic [7:0] eo);
      vec_t v;
      v.do_rst = r; v.k = k; v.rin = rin; v.s = s; v.tick = tick; v.er = er; v.eo = eo;
      vecs.push_back(v);
   endfunction

   task automatic check_output(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, sample #1 after the posedge, then drop the strobes
   task automatic apply_stimulus(input logic rin, input logic [7:0] s, input logic tick);
      @(negedge clk);
      bus.rdy_in    = rin;
      bus.sample_in = s;
      bus.out_tick  = tick;
      @(posedge clk);
      #1;
      bus.rdy_in   = 1'b0;
      bus.out_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic expect_tick(input string name, input logic er, input int eo);
      apply_stimulus(1'b0, 8'd0, 1'b1);
      check_output({name, " rdy_out"}, int'(bus.rdy_out), int'(er));
      check_output({name, " sample_out"}, int'(bus.sample_out), eo);
   endtask

   initial begin
      bus.k         = 3'd2;
      bus.rdy_in    = 1'b0;
      bus.sample_in = '0;
      bus.out_tick  = 1'b0;

      // basic ramp, k=2
      add_vec(1, 2, 1,   0, 0, 0,   0);
      add_vec(0, 2, 0,   0, 0, 0,   0);
      add_vec(0, 2, 1, 100, 0, 0,   0);
      add_vec(0, 2, 0,   0, 0, 0,   0);
      add_vec(0, 2, 0,   0, 1, 1,   0);
      add_vec(0, 2, 0,   0, 1, 1,  25);
      add_vec(0, 2, 0,   0, 1, 1,  50);
      add_vec(0, 2, 0,   0, 1, 1,  75);
      add_vec(0, 2, 0,   0, 1, 0,   0);
      add_vec(0, 2, 1,  20, 0, 0,   0);
      add_vec(0, 2, 0,   0, 0, 0,   0);
      add_vec(0, 2, 0,   0, 1, 1, 100);
      add_vec(0, 2, 0,   0, 1, 1,  80);
      add_vec(0, 2, 0,   0, 1, 1,  60);
      add_vec(0, 2, 0,   0, 1, 1,  40);
      add_vec(0, 2, 0,   0, 1, 0,   0);
      // truncation, k=2
      add_vec(1, 2, 1,  10, 0, 0,   0);
      add_vec(0, 2, 0,   0, 0, 0,   0);
      add_vec(0, 2, 1,  13, 0, 0,   0);
      add_vec(0, 2, 0,   0, 0, 0,   0);
      add_vec(0, 2, 0,   0, 1, 1,  10);
      add_vec(0, 2, 0,   0, 1, 1,  10);
      add_vec(0, 2, 0,   0, 1, 1,  11);
      add_vec(0, 2, 0,   0, 1, 1,  12);
      // k=0 passthrough; first tick lands in PRIME and is ignored
      add_vec(1, 0, 0,   0, 1, 0,   0);
      add_vec(0, 0, 1,   5, 0, 0,   0);
      add_vec(0, 0, 0,   0, 0, 0,   0);
      add_vec(0, 0, 1,   7, 0, 0,   0);
      add_vec(0, 0, 0,   0, 0, 0,   0);
      add_vec(0, 0, 0,   0, 1, 1,   5);
      add_vec(0, 0, 0,   0, 1, 0,   0);
      add_vec(0, 0, 1,   9, 0, 0,   0);
      add_vec(0, 0, 0,   0, 0, 0,   0);
      add_vec(0, 0, 0,   0, 1, 1,   7);
      add_vec(0, 0, 0,   0, 1, 0,   0);
      // k above the maximum clamps to 4, so 16 points per interval
      add_vec(1, 7, 1,   0, 0, 0,   0);
      add_vec(0, 7, 0,   0, 0, 0,   0);
      add_vec(0, 7, 1, 160, 0, 0,   0);
      add_vec(0, 7, 0,   0, 0, 0,   0);
      add_vec(0, 7, 0,   0, 1, 1,   0);
      add_vec(0, 7, 0,   0, 1, 1,  10);

      repeat (3) @(posedge clk);
      #1;
      check_output("reset in_ready", int'(bus.in_ready), 1);
      check_output("reset rdy_out", int'(bus.rdy_out), 0);
      check_output("reset sample_out", int'(bus.sample_out), 0);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].do_rst) do_reset();
         bus.k = vecs[i].k;
         apply_stimulus(vecs[i].rin, vecs[i].s, vecs[i].tick);
         check_output($sformatf("vec[%0d] rdy_out", i), int'(bus.rdy_out), int'(vecs[i].er));
         check_output($sformatf("vec[%0d] sample_out", i), int'(bus.sample_out), int'(vecs[i].eo));
      end

      // overrun: k=3, second sample offered while the slot already holds one is dropped
      do_reset();
      bus.k = 3'd3;
`ifdef INTERP_OVERRUN_FLAG_EN
      check_output("ovr flag after reset", int'(bus.overrun), 0);
`endif
      apply_stimulus(1'b1, 8'd0, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      apply_stimulus(1'b1, 8'd80, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      expect_tick("ovr s1 i0", 1'b1, 0);
      apply_stimulus(1'b1, 8'd40, 1'b0);
      check_output("ovr in_ready after A", int'(bus.in_ready), 0);
      apply_stimulus(1'b1, 8'd200, 1'b0);
      check_output("ovr in_ready after B", int'(bus.in_ready), 0);
`ifdef INTERP_OVERRUN_FLAG_EN
      check_output("ovr flag set", int'(bus.overrun), 1);
`endif
      for (int i = 1; i < 8; i++) expect_tick($sformatf("ovr s1 i%0d", i), 1'b1, 10 * i);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      check_output("ovr in_ready after start", int'(bus.in_ready), 1);
      for (int i = 0; i < 8; i++) expect_tick($sformatf("ovr s2 i%0d", i), 1'b1, 80 - 5 * i);
      expect_tick("ovr idle", 1'b0, 0);
`ifdef INTERP_OVERRUN_FLAG_EN
      check_output("ovr flag sticky", int'(bus.overrun), 1);
      do_reset();
      check_output("ovr flag cleared", int'(bus.overrun), 0);
`endif

      // k change mid-segment takes effect only at the next segment
      do_reset();
      bus.k = 3'd2;
      apply_stimulus(1'b1, 8'd0, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      apply_stimulus(1'b1, 8'd40, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      expect_tick("kchg s1 i0", 1'b1, 0);
      bus.k = 3'd1;
      for (int i = 1; i < 4; i++) expect_tick($sformatf("kchg s1 i%0d", i), 1'b1, 10 * i);
      expect_tick("kchg gap", 1'b0, 0);
      apply_stimulus(1'b1, 8'd20, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      expect_tick("kchg s2 i0", 1'b1, 40);
      expect_tick("kchg s2 i1", 1'b1, 30);
      expect_tick("kchg s2 end", 1'b0, 0);

      // asynchronous reset between ticks with the slot full and an output just emitted
      do_reset();
      bus.k = 3'd2;
      apply_stimulus(1'b1, 8'd0, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      apply_stimulus(1'b1, 8'd40, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      expect_tick("rst pre i0", 1'b1, 0);
      apply_stimulus(1'b1, 8'd60, 1'b0);
      expect_tick("rst pre i1", 1'b1, 10);
      #2 rst = 1'b1;
      #1;
      check_output("rst async rdy_out", int'(bus.rdy_out), 0);
      check_output("rst async sample_out", int'(bus.sample_out), 0);
      check_output("rst async in_ready", int'(bus.in_ready), 1);
      #1 rst = 1'b0;
      apply_stimulus(1'b1, 8'd90, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      expect_tick("rst reprime t0", 1'b0, 0);
      expect_tick("rst reprime t1", 1'b0, 0);
      apply_stimulus(1'b1, 8'd30, 1'b0);
      apply_stimulus(1'b0, 8'd0, 1'b0);
      expect_tick("rst after i0", 1'b1, 90);
      expect_tick("rst after i1", 1'b1, 75);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
